golomb_code_unpacker: RTL and testbench
=======================================

Name: golomb_code_unpacker

Overview:
- Decoder-side front end for the JPEG-LS regular-mode Golomb path.
- Accepts the compressed bytestream one byte at a time and extracts one limited-length Golomb-Rice codeword per start_dec request.
- Returns the mapped error value, the codeword length and a limit-overflow flag.
- Consumer of the stream the encoder's stage-7 packer produces; feeds the decoder's inverse error-mapping stage.

Parameters:
- value_width, 16: width of decoded mapped error value.
- k_width, 5: width of Golomb parameter k (0..16 used).
- limit_width, 7: width of LIMIT and of code_length.
- qbpp_width, 5: width of qbpp (escape remainder bit count).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- byte_in  in  8  next stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  unpacker accepts byte_in this cycle (bit buffer empty).
- start_dec  in  1  one-cycle request to decode one codeword; sampled only in IDLE.
- k_in  in  k_width  Golomb parameter, sampled with start_dec.
- limit_in  in  limit_width  LIMIT, sampled with start_dec.
- qbpp_in  in  qbpp_width  escape remainder bits, sampled with start_dec.
- align  in  1  in IDLE: discard remaining buffered bits (byte-align).
- busy  out  1  state is not IDLE.
- value_out  out  value_width  decoded mapped error value; held until next DONE.
- code_length  out  limit_width  bits consumed by the codeword.
- limit_overflow_out  out  1  codeword was an escape code.
- code_error  out  1  unary prefix exceeded LIMIT-qbpp-1 zeros.
- value_valid  out  1  one-cycle strobe: outputs are updated.

Behaviour:
- Bit buffer: 8-bit shift register plus bit_count (0..8), MSB-first.
- byte_ready = (bit_count==0), combinational; it is 1 during and after reset.
- Load: byte_valid & byte_ready loads byte_in and sets bit_count=8. No bit is consumed in a load cycle.
- Consumption: at most one bit per cycle, only while bit_count>0 in UNARY/REMAINDER/ESCAPE. States stall while the buffer is empty.
- Buffered bits persist across codewords; leftover bits feed the next decode.
- IDLE:
  - start_dec latches k, limit and qbpp, clears q, r, len and flags, then goes to UNARY.
  - align (ignored outside IDLE) sets bit_count=0.
  - If start_dec and align arrive in the same cycle, align is applied first.
- UNARY: thr = limit-qbpp-1.
  - 0 bit with q<thr: q++.
  - 0 bit with q==thr: code_error=1, go to DONE.
  - 1 bit with q<thr: go to REMAINDER, or go directly to DONE if k==0.
  - 1 bit with q==thr: go to ESCAPE.
- REMAINDER: shift k bits into r, then go to DONE with value=(q<<k)|r, truncated to value_width, and code_length=q+1+k.
- ESCAPE: shift qbpp bits into r, then go to DONE with value=r+1, limit_overflow_out=1, code_length=limit.
- code_error result: value_out=0, code_length=q+1.
- DONE: one cycle; outputs registered and value_valid=1; then IDLE.
  - start_dec asserted in DONE is ignored.
- Latency: codeword bits + byte-load cycles + 1 (the DONE cycle) from the cycle after start_dec.
- Reset value of all registered outputs, q, r, bit_count and state (IDLE) is 0.
  - Reset mid-decode abandons the codeword and empties the buffer; no value_valid is issued.

Optional Feature:
- Macro: JPEGLS_BIT_STUFF_EN.
- Defined: a loaded byte of 0xFF sets stuff_pending. The next loaded byte has its MSB discarded (bit_count=7, buffer starts at bit 6), and stuff_pending is then cleared. Reset and align also clear stuff_pending.
- Undefined: every byte contributes 8 bits; no stuff_pending logic is built.

Test Plan:
- Basic decode: k=2, limit=32, qbpp=8, byte 0x2C (00101100) -> value_out=9, code_length=5, limit_overflow_out=0; 3 bits (100) remain. Next start_dec with k=0 -> value_out=0, code_length=1.
- Escape: limit=32, qbpp=8, k=3, bytes 0x00, 0x00, 0x01, 0x2A -> limit_overflow_out=1, value_out=43, code_length=32, code_error=0, bit_count=0 afterwards.
- Error: limit=32, qbpp=8, bytes 0x00, 0x00, 0x00 -> code_error=1 after the 24th zero, value_out=0, code_length=24; value_valid pulses exactly once.
- Stall and align: byte_valid held low for 5 cycles mid-UNARY -> busy stays 1, no value_valid. Then align in IDLE with 3 bits buffered -> byte_ready=1 next cycle.
- Reset: reset low during REMAINDER -> all outputs 0 and byte_ready=1 immediately (asynchronous). After release, a fresh decode of 0x2C gives value_out=9.
- Bit stuffing (k=0, limit=32, qbpp=8), bytes 0xFF, 0x80, 0x80:
  - With JPEGLS_BIT_STUFF_EN: 8 decodes of value 0, then one decode of value 7 with code_length 8.
  - Without JPEGLS_BIT_STUFF_EN: the 9th decode gives value 0.

Source files
------------

// File: rtl/golomb_code_unpacker.sv
// golomb_code_unpacker: JPEG-LS regular-mode Golomb-Rice codeword extractor.
// Pulls an MSB-first bytestream through an 8-bit bit buffer and decodes one
// limited-length Golomb codeword per start_dec request.
// Optional build macro: JPEGLS_BIT_STUFF_EN (drop the MSB of the byte after 0xFF).
module golomb_code_unpacker #(
  parameter int value_width = 16,
  parameter int k_width     = 5,
  parameter int limit_width = 7,
  parameter int qbpp_width  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic                   start_dec,
  input  logic [k_width-1:0]     k_in,
  input  logic [limit_width-1:0] limit_in,
  input  logic [qbpp_width-1:0]  qbpp_in,
  input  logic                   align,
  output logic                   busy,
  output logic [value_width-1:0] value_out,
  output logic [limit_width-1:0] code_length,
  output logic                   limit_overflow_out,
  output logic                   code_error,
  output logic                   value_valid
);

  localparam int CW = ((k_width > qbpp_width) ? k_width : qbpp_width) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNARY,
    S_REMAINDER,
    S_ESCAPE,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_buf;
  logic [3:0]             r_bit_count;
  logic [k_width-1:0]     r_k;
  logic [limit_width-1:0] r_limit;
  logic [qbpp_width-1:0]  r_qbpp;
  logic [limit_width-1:0] r_q;
  logic [value_width-1:0] r_r;
  logic [CW-1:0]          r_nbits;
  logic [value_width-1:0] r_value;
  logic [limit_width-1:0] r_len;
  logic                   r_ovf;
  logic                   r_err;
  logic                   r_valid;

  logic                   w_bit;
  logic                   w_consume;
  logic                   w_load;
  logic                   w_align;
  logic [limit_width-1:0] w_thr;
  logic                   w_at_thr;
  logic [value_width-1:0] w_r_next;
  logic [CW-1:0]          w_nbits_next;

  // Bit-buffer status and per-cycle datapath terms.
  always_comb begin
    byte_ready   = (r_bit_count == 4'd0);
    w_bit        = r_buf[7];
    w_consume    = (r_bit_count != 4'd0) &&
                   ((r_state == S_UNARY) || (r_state == S_REMAINDER) || (r_state == S_ESCAPE));
    w_load       = byte_valid && (r_bit_count == 4'd0);
    w_align      = align && (r_state == S_IDLE);
    w_thr        = r_limit - limit_width'(r_qbpp) - limit_width'(1);
    w_at_thr     = (r_q >= w_thr);
    w_r_next     = {r_r[value_width-2:0], w_bit};
    w_nbits_next = r_nbits + CW'(1);
  end

`ifdef JPEGLS_BIT_STUFF_EN
  logic r_stuff_pending;

  // Bit buffer with stuffed-bit removal: the byte after 0xFF loses its MSB.
  // A load can only happen on an empty buffer, so it takes priority over align.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf           <= '0;
      r_bit_count     <= '0;
      r_stuff_pending <= 1'b0;
    end else if (w_load) begin
      if (r_stuff_pending && !w_align) begin
        r_buf       <= {byte_in[6:0], 1'b0};
        r_bit_count <= 4'd7;
      end else begin
        r_buf       <= byte_in;
        r_bit_count <= 4'd8;
      end
      r_stuff_pending <= (byte_in == 8'hFF);
    end else if (w_consume) begin
      r_buf       <= {r_buf[6:0], 1'b0};
      r_bit_count <= r_bit_count - 4'd1;
    end else if (w_align) begin
      r_bit_count     <= '0;
      r_stuff_pending <= 1'b0;
    end
  end
`else
  // Bit buffer: load a whole byte when empty, shift out one bit per consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf       <= '0;
      r_bit_count <= '0;
    end else if (w_load) begin
      r_buf       <= byte_in;
      r_bit_count <= 4'd8;
    end else if (w_consume) begin
      r_buf       <= {r_buf[6:0], 1'b0};
      r_bit_count <= r_bit_count - 4'd1;
    end else if (w_align) begin
      r_bit_count <= '0;
    end
  end
`endif

  // Decode FSM; results are registered on the edge entering DONE so that
  // value_valid is high exactly during the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_limit <= '0;
      r_qbpp  <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_nbits <= '0;
      r_value <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_dec) begin
            r_k     <= k_in;
            r_limit <= limit_in;
            r_qbpp  <= qbpp_in;
            r_q     <= '0;
            r_r     <= '0;
            r_nbits <= '0;
            r_state <= S_UNARY;
          end
        end
        S_UNARY: begin
          if (w_consume) begin
            if (!w_bit) begin
              if (w_at_thr) begin
                r_value <= '0;
                r_len   <= r_q + limit_width'(1);
                r_ovf   <= 1'b0;
                r_err   <= 1'b1;
                r_valid <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_q <= r_q + limit_width'(1);
              end
            end else if (w_at_thr) begin
              if (r_qbpp == '0) begin
                r_value <= value_width'(1);
                r_len   <= r_limit;
                r_ovf   <= 1'b1;
                r_err   <= 1'b0;
                r_valid <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_ESCAPE;
              end
            end else if (r_k == '0) begin
              r_value <= value_width'(r_q);
              r_len   <= r_q + limit_width'(1);
              r_ovf   <= 1'b0;
              r_err   <= 1'b0;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_REMAINDER;
            end
          end
        end
        S_REMAINDER: begin
          if (w_consume) begin
            r_r     <= w_r_next;
            r_nbits <= w_nbits_next;
            if (w_nbits_next == CW'(r_k)) begin
              r_value <= (value_width'(r_q) << r_k) | w_r_next;
              r_len   <= r_q + limit_width'(1) + limit_width'(r_k);
              r_ovf   <= 1'b0;
              r_err   <= 1'b0;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_ESCAPE: begin
          if (w_consume) begin
            r_r     <= w_r_next;
            r_nbits <= w_nbits_next;
            if (w_nbits_next == CW'(r_qbpp)) begin
              r_value <= w_r_next + value_width'(1);
              r_len   <= r_limit;
              r_ovf   <= 1'b1;
              r_err   <= 1'b0;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    busy               = (r_state != S_IDLE);
    value_out          = r_value;
    code_length        = r_len;
    limit_overflow_out = r_ovf;
    code_error         = r_err;
    value_valid        = r_valid;
  end

endmodule

// File: tb/tb_golomb_code_unpacker.sv
// Directed self-checking bench for golomb_code_unpacker.
module tb_golomb_code_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        start_dec;
  logic [4:0]  k_in;
  logic [6:0]  limit_in;
  logic [4:0]  qbpp_in;
  logic        align;
  logic        busy;
  logic [15:0] value_out;
  logic [6:0]  code_length;
  logic        limit_overflow_out;
  logic        code_error;
  logic        value_valid;

  int errors = 0;
  int checks = 0;
  logic [7:0] fifo[$];

  golomb_code_unpacker #(
    .value_width(16),
    .k_width(5),
    .limit_width(7),
    .qbpp_width(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .start_dec(start_dec),
    .k_in(k_in),
    .limit_in(limit_in),
    .qbpp_in(qbpp_in),
    .align(align),
    .busy(busy),
    .value_out(value_out),
    .code_length(code_length),
    .limit_overflow_out(limit_overflow_out),
    .code_error(code_error),
    .value_valid(value_valid)
  );

  always #5 clk = ~clk;

  // Byte feeder: present the queue head whenever the buffer is empty.
  // A byte presented at one falling edge is taken at the next rising edge.
  always @(negedge clk) begin
    if (byte_valid) void'(fifo.pop_front());
    if (reset && fifo.size() > 0 && byte_ready) begin
      byte_valid = 1'b1;
      byte_in    = fifo[0];
    end else begin
      byte_valid = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_pulse(input logic [4:0] k, input logic [6:0] lim, input logic [4:0] qb);
    @(negedge clk);
    start_dec = 1'b1;
    k_in      = k;
    limit_in  = lim;
    qbpp_in   = qb;
    @(negedge clk);
    start_dec = 1'b0;
  endtask

  task automatic wait_done(output logic [15:0] v, output logic [6:0] l,
                           output logic ov, output logic er, output int cnt);
    cnt = 0;
    v = '0; l = '0; ov = 1'b0; er = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (value_valid) begin
        cnt++;
        v  = value_out;
        l  = code_length;
        ov = limit_overflow_out;
        er = code_error;
      end
      if (!busy && cnt > 0) break;
    end
  endtask

  logic [15:0] v;
  logic [6:0]  l;
  logic        ov, er;
  int          cnt, nv, nb;

  initial begin
    reset      = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
    start_dec  = 1'b0;
    k_in       = '0;
    limit_in   = '0;
    qbpp_in    = '0;
    align      = 1'b0;

    // Reset state
    #1;
    chk("rst_byte_ready", byte_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_value", value_out, 0);
    chk("rst_len", code_length, 0);
    chk("rst_flags", {limit_overflow_out, code_error, value_valid}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Basic decode: 0x2C, k=2 -> 9 / 5 bits, leaves "100"
    fifo.push_back(8'h2C);
    repeat (3) @(negedge clk);
    chk("load_ready_low", byte_ready, 0);
    start_pulse(5'd2, 7'd32, 5'd8);
    wait_done(v, l, ov, er, cnt);
    chk("basic_cnt", cnt, 1);
    chk("basic_value", v, 9);
    chk("basic_len", l, 5);
    chk("basic_ovf", ov, 0);
    chk("basic_err", er, 0);

    // Leftover bits: k=0 decodes the "1" -> 0 / 1 bit, leaves "00"
    start_pulse(5'd0, 7'd32, 5'd8);
    wait_done(v, l, ov, er, cnt);
    chk("k0_cnt", cnt, 1);
    chk("k0_value", v, 0);
    chk("k0_len", l, 1);

    // Stall mid-UNARY with no bytes available
    start_pulse(5'd2, 7'd32, 5'd8);
    nv = 0; nb = 0;
    repeat (8) begin
      @(negedge clk);
      if (value_valid) nv++;
      if (!busy) nb++;
    end
    chk("stall_no_valid", nv, 0);
    chk("stall_not_busy", nb, 0);
    // "00" + 0x24 (00100100): q=4, r=00 -> 16 / 7 bits, leaves "100"
    fifo.push_back(8'h24);
    wait_done(v, l, ov, er, cnt);
    chk("stall_cnt", cnt, 1);
    chk("stall_value", v, 16);
    chk("stall_len", l, 7);

    // Align discards the three leftover bits
    chk("pre_align_ready", byte_ready, 0);
    @(negedge clk);
    align = 1'b1;
    @(negedge clk);
    align = 1'b0;
    chk("align_ready", byte_ready, 1);

    // Reset during REMAINDER
    fifo.push_back(8'h2C);
    repeat (3) @(negedge clk);
    start_pulse(5'd2, 7'd32, 5'd8);
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_value_held", value_out, 16);
    #2;
    reset = 1'b0;
    #1;
    chk("async_value", value_out, 0);
    chk("async_len", code_length, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", byte_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    nv = 0;
    repeat (4) begin
      @(negedge clk);
      if (value_valid) nv++;
    end
    chk("post_rst_no_valid", nv, 0);
    fifo.push_back(8'h2C);
    repeat (3) @(negedge clk);
    start_pulse(5'd2, 7'd32, 5'd8);
    wait_done(v, l, ov, er, cnt);
    chk("post_rst_cnt", cnt, 1);
    chk("post_rst_value", v, 9);
    chk("post_rst_len", l, 5);
    @(negedge clk);
    align = 1'b1;
    @(negedge clk);
    align = 1'b0;

    // Escape: 23 zeros, 1, then 8 bits 0x2A -> 43 / 32 bits
    fifo.push_back(8'h00);
    fifo.push_back(8'h00);
    fifo.push_back(8'h01);
    fifo.push_back(8'h2A);
    start_pulse(5'd3, 7'd32, 5'd8);
    wait_done(v, l, ov, er, cnt);
    chk("esc_cnt", cnt, 1);
    chk("esc_value", v, 43);
    chk("esc_len", l, 32);
    chk("esc_ovf", ov, 1);
    chk("esc_err", er, 0);
    chk("esc_buffer_empty", byte_ready, 1);

    // Error: 24 zeros
    fifo.push_back(8'h00);
    fifo.push_back(8'h00);
    fifo.push_back(8'h00);
    start_pulse(5'd2, 7'd32, 5'd8);
    wait_done(v, l, ov, er, cnt);
    chk("err_cnt", cnt, 1);
    chk("err_flag", er, 1);
    chk("err_value", v, 0);
    chk("err_len", l, 24);
    chk("err_ovf", ov, 0);

    // Bit stuffing stream 0xFF 0x80 0x80 with k=0
    fifo.push_back(8'hFF);
    fifo.push_back(8'h80);
    fifo.push_back(8'h80);
    for (int i = 0; i < 8; i++) begin
      start_pulse(5'd0, 7'd32, 5'd8);
      wait_done(v, l, ov, er, cnt);
      chk("ff_value", v, 0);
      chk("ff_len", l, 1);
    end
    start_pulse(5'd0, 7'd32, 5'd8);
    wait_done(v, l, ov, er, cnt);
    chk("ninth_cnt", cnt, 1);
`ifdef JPEGLS_BIT_STUFF_EN
    chk("ninth_value", v, 7);
    chk("ninth_len", l, 8);
`else
    chk("ninth_value", v, 0);
    chk("ninth_len", l, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
